// File: rtl/fb_access_arbiter.sv
// Shares the single Framebuffer port between a pixel writer and a chunk reader.
// Writer has priority; a starvation count bounds consecutive writes while a read waits.
module fb_access_arbiter #(
  parameter int FB_W         = 640,
  parameter int FB_H         = 480,
  parameter int WRITE_CYCLES = 3,
  parameter int READ_TIMEOUT = 64,
  parameter int MAX_WR_BURST = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic [31:0]   wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [9:0]    rd_x,
  input  logic [9:0]    rd_y,
  output logic          rd_ack,
  output logic [99:0]   rd_data,
  output logic          rd_timeout,
  output logic          range_err,
  output logic [9:0]    fb_x_pos,
  output logic [9:0]    fb_y_pos,
  output logic [31:0]   fb_data_in,
  output logic          fb_read,
  output logic          fb_write,
  input  logic [99:0]   fb_data_chunk,
  input  logic          fb_data_ready,
  output logic          busy
);

  localparam int CNT_MAX = (READ_TIMEOUT > WRITE_CYCLES) ? READ_TIMEOUT : WRITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ST_W    = $clog2(MAX_WR_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [ST_W-1:0]   starve_r;
  logic [9:0]        x_r, y_r;
  logic [31:0]       data_r;
  logic [99:0]       rd_data_r;
  logic              wr_ack_r, rd_ack_r, rd_timeout_r, range_err_r;
  logic              fb_read_r, fb_write_r, busy_r;

  logic wr_oor_s, rd_oor_s, grant_oor_s;
  logic wr_grant_s, rd_grant_s;
  logic wr_done_s, rd_done_s, rd_expire_s;
  logic wr_ack_nxt_s, rd_ack_nxt_s, rd_timeout_nxt_s, range_err_nxt_s;
  logic fb_read_nxt_s, fb_write_nxt_s, busy_nxt_s;

  // Arbitration, range check and phase-completion conditions.
  always_comb begin
    wr_oor_s = ({1'b0, wr_x} >= 11'(FB_W)) || ({1'b0, wr_y} >= 11'(FB_H));
    rd_oor_s = ({1'b0, rd_x} >= 11'(FB_W)) || ({1'b0, rd_y} >= 11'(FB_H));
    if (state_r == IDLE) begin
      wr_grant_s = wr_req && (!rd_req || (starve_r < ST_W'(MAX_WR_BURST)));
      rd_grant_s = !wr_grant_s && rd_req;
    end else begin
      wr_grant_s = 1'b0;
      rd_grant_s = 1'b0;
    end
    grant_oor_s = wr_grant_s ? wr_oor_s : (rd_grant_s ? rd_oor_s : 1'b0);
    wr_done_s   = (state_r == WRITE) && (cnt_r == CNT_W'(WRITE_CYCLES - 1));
    rd_done_s   = (state_r == READ) && fb_data_ready;
    // Ready in the final wait cycle still counts as a successful read.
    rd_expire_s = (state_r == READ) && !fb_data_ready &&
                  (cnt_r == CNT_W'(READ_TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_grant_s) begin
          next_state_s = grant_oor_s ? DONE : WRITE;
        end else if (rd_grant_s) begin
          next_state_s = grant_oor_s ? DONE : READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_done_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WRITE;
        end
      end
      READ: begin
        if (rd_done_s || rd_expire_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = READ;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; values land in registers on the same edge as the state.
  always_comb begin
    wr_ack_nxt_s     = wr_done_s;
    rd_ack_nxt_s     = rd_done_s;
    rd_timeout_nxt_s = rd_expire_s;
    range_err_nxt_s  = (wr_grant_s || rd_grant_s) && grant_oor_s;
    fb_write_nxt_s   = (next_state_s == WRITE);
    fb_read_nxt_s    = (next_state_s == READ);
    busy_nxt_s       = (next_state_s != IDLE);
  end

  // Registered status and strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack_r     <= 1'b0;
      rd_ack_r     <= 1'b0;
      rd_timeout_r <= 1'b0;
      range_err_r  <= 1'b0;
      fb_write_r   <= 1'b0;
      fb_read_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      wr_ack_r     <= wr_ack_nxt_s;
      rd_ack_r     <= rd_ack_nxt_s;
      rd_timeout_r <= rd_timeout_nxt_s;
      range_err_r  <= range_err_nxt_s;
      fb_write_r   <= fb_write_nxt_s;
      fb_read_r    <= fb_read_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  // Phase counter, starvation count, operand latches and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      starve_r  <= '0;
      x_r       <= 10'd0;
      y_r       <= 10'd0;
      data_r    <= 32'd0;
      rd_data_r <= 100'd0;
    end else begin
      if (next_state_s != state_r) begin
        cnt_r <= '0;
      end else if ((state_r == WRITE) || (state_r == READ)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      if (state_r == IDLE) begin
        if (rd_grant_s || !rd_req) begin
          starve_r <= '0;
        end else if (wr_grant_s && (starve_r < ST_W'(MAX_WR_BURST))) begin
          starve_r <= starve_r + ST_W'(1);
        end else begin
          starve_r <= starve_r;
        end
      end else begin
        starve_r <= starve_r;
      end

      if (wr_grant_s) begin
        x_r    <= wr_x;
        y_r    <= wr_y;
        data_r <= wr_data;
      end else if (rd_grant_s) begin
        x_r <= rd_x;
        y_r <= rd_y;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end

      if (rd_done_s) begin
        rd_data_r <= fb_data_chunk;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign wr_ack     = wr_ack_r;
  assign rd_ack     = rd_ack_r;
  assign rd_timeout = rd_timeout_r;
  assign range_err  = range_err_r;
  assign rd_data    = rd_data_r;
  assign fb_x_pos   = x_r;
  assign fb_y_pos   = y_r;
  assign fb_data_in = data_r;
  assign fb_write   = fb_write_r;
  assign fb_read    = fb_read_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: write/read timing, starvation pattern,
// read timeout, range rejection and mid-write reset.
module tb_fb_access_arbiter;

  logic          clk;
  logic          reset_n;
  logic          wr_req;
  logic [9:0]    wr_x, wr_y;
  logic [31:0]   wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [9:0]    rd_x, rd_y;
  logic          rd_ack;
  logic [99:0]   rd_data;
  logic          rd_timeout;
  logic          range_err;
  logic [9:0]    fb_x_pos, fb_y_pos;
  logic [31:0]   fb_data_in;
  logic          fb_read, fb_write;
  logic [99:0]   fb_data_chunk;
  logic          fb_data_ready;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [99:0] CHUNK_A = {4'h1, 96'h0123_4567_89AB_CDEF_0000_00A5};
  localparam logic [99:0] CHUNK_B = {4'h7, 96'hCAFE_F00D_1234_5678_9ABC_DE3C};
  localparam logic [99:0] CHUNK_C = {4'hF, 96'hFFFF_0000_FFFF_0000_FFFF_0000};

  fb_access_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_req        (wr_req),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .rd_req        (rd_req),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_timeout    (rd_timeout),
    .range_err     (range_err),
    .fb_x_pos      (fb_x_pos),
    .fb_y_pos      (fb_y_pos),
    .fb_data_in    (fb_data_in),
    .fb_read       (fb_read),
    .fb_write      (fb_write),
    .fb_data_chunk (fb_data_chunk),
    .fb_data_ready (fb_data_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit exp_is_rd [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int ev;

  initial begin
    reset_n = 1'b0; wr_req = 1'b0; wr_x = 10'd0; wr_y = 10'd0; wr_data = 32'd0;
    rd_req = 1'b0; rd_x = 10'd0; rd_y = 10'd0;
    fb_data_chunk = 100'd0; fb_data_ready = 1'b0;
    step(); step();

    // Reset state
    check1("rst_busy", busy, 1'b0);
    check1("rst_fb_write", fb_write, 1'b0);
    check1("rst_fb_read", fb_read, 1'b0);
    check1("rst_wr_ack", wr_ack, 1'b0);
    check1("rst_rd_ack", rd_ack, 1'b0);
    check1("rst_rd_timeout", rd_timeout, 1'b0);
    check1("rst_range_err", range_err, 1'b0);
    checkw("rst_rd_data", rd_data, 100'd0);
    checkw("rst_fb_x_pos", 100'(fb_x_pos), 100'd0);
    checkw("rst_fb_data_in", 100'(fb_data_in), 100'd0);
    reset_n = 1'b1;
    step();

    // Single write (8,8) 0xDEADBEEF
    wr_req = 1'b1; wr_x = 10'd8; wr_y = 10'd8; wr_data = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      check1("wr_fb_write_hi", fb_write, 1'b1);
      check1("wr_ack_early", wr_ack, 1'b0);
      checkw("wr_fb_x", 100'(fb_x_pos), 100'd8);
      checkw("wr_fb_y", 100'(fb_y_pos), 100'd8);
      checkw("wr_fb_data", 100'(fb_data_in), 100'hDEADBEEF);
    end
    step();
    check1("wr_ack_c4", wr_ack, 1'b1);
    check1("wr_fb_write_c4", fb_write, 1'b0);
    check1("wr_busy_c4", busy, 1'b1);
    wr_req = 1'b0;
    step();
    check1("wr_ack_c5", wr_ack, 1'b0);
    check1("wr_busy_c5", busy, 1'b0);

    // Read with latency 2
    rd_req = 1'b1; rd_x = 10'd8; rd_y = 10'd8; fb_data_chunk = CHUNK_A;
    step();
    check1("rd_fb_read_c1", fb_read, 1'b1);
    check1("rd_ack_c1", rd_ack, 1'b0);
    step();
    check1("rd_fb_read_c2", fb_read, 1'b1);
    fb_data_ready = 1'b1;
    step();
    fb_data_ready = 1'b0;
    check1("rd_ack_c3", rd_ack, 1'b1);
    check1("rd_fb_read_c3", fb_read, 1'b0);
    checkw("rd_data_low", 100'(rd_data[7:0]), 100'hA5);
    checkw("rd_data_full", rd_data, CHUNK_A);
    rd_req = 1'b0;
    step();
    check1("rd_ack_c4", rd_ack, 1'b0);
    check1("rd_busy_c4", busy, 1'b0);

    // Starvation: both requests held, ready held high
    wr_req = 1'b1; wr_x = 10'd1; wr_y = 10'd2; wr_data = 32'h0000_1111;
    rd_req = 1'b1; rd_x = 10'd3; rd_y = 10'd4;
    fb_data_chunk = CHUNK_B; fb_data_ready = 1'b1;
    ev = 0;
    for (int c = 0; c < 120 && ev < 10; c++) begin
      step();
      if (wr_ack || rd_ack) begin
        check1("starve_one_ack", wr_ack & rd_ack, 1'b0);
        check1("starve_order", rd_ack, exp_is_rd[ev]);
        ev++;
      end
    end
    checkw("starve_events", 100'(ev), 100'd10);
    wr_req = 1'b0; rd_req = 1'b0; fb_data_ready = 1'b0;
    step();
    check1("starve_idle", busy, 1'b0);
    checkw("starve_rd_data", rd_data, CHUNK_B);

    // Timeout: ready stuck low
    rd_req = 1'b1; rd_x = 10'd5; rd_y = 10'd6; fb_data_chunk = CHUNK_C;
    for (int c = 1; c <= 64; c++) begin
      step();
      check1("to_fb_read", fb_read, 1'b1);
      check1("to_early", rd_timeout, 1'b0);
    end
    step();
    check1("to_pulse_c65", rd_timeout, 1'b1);
    check1("to_no_ack", rd_ack, 1'b0);
    check1("to_fb_read_c65", fb_read, 1'b0);
    checkw("to_rd_data_kept", rd_data, CHUNK_B);
    rd_req = 1'b0;
    step();
    check1("to_pulse_c66", rd_timeout, 1'b0);
    wr_req = 1'b1; wr_x = 10'd10; wr_y = 10'd20; wr_data = 32'h1234_5678;
    step();
    check1("to_next_wr", fb_write, 1'b1);
    checkw("to_next_wr_x", 100'(fb_x_pos), 100'd10);
    step(); step(); step();
    check1("to_next_wr_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();

    // Range error: write x=640, then read y=480
    wr_req = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 32'hAAAA_5555;
    step();
    check1("rng_wr_err", range_err, 1'b1);
    check1("rng_wr_fb_write", fb_write, 1'b0);
    check1("rng_wr_ack", wr_ack, 1'b0);
    wr_req = 1'b0;
    step();
    check1("rng_wr_err_c2", range_err, 1'b0);
    check1("rng_wr_fb_write_c2", fb_write, 1'b0);
    check1("rng_wr_busy_c2", busy, 1'b0);
    rd_req = 1'b1; rd_x = 10'd0; rd_y = 10'd480;
    step();
    check1("rng_rd_err", range_err, 1'b1);
    check1("rng_rd_fb_read", fb_read, 1'b0);
    rd_req = 1'b0;
    step();
    check1("rng_rd_err_c2", range_err, 1'b0);
    check1("rng_rd_fb_read_c2", fb_read, 1'b0);
    // Boundary addresses are valid
    wr_req = 1'b1; wr_x = 10'd639; wr_y = 10'd479; wr_data = 32'h0BAD_CAFE;
    step();
    check1("rng_edge_ok", range_err, 1'b0);
    check1("rng_edge_write", fb_write, 1'b1);
    step(); step(); step();
    check1("rng_edge_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();

    // Reset in cycle 2 of a write
    wr_req = 1'b1; wr_x = 10'd7; wr_y = 10'd9; wr_data = 32'h5A5A_5A5A;
    step(); step();
    check1("mrst_fb_write_c2", fb_write, 1'b1);
    #1;
    reset_n = 1'b0;
    wr_req = 1'b0;
    #1;
    check1("mrst_fb_write_drop", fb_write, 1'b0);
    check1("mrst_busy_drop", busy, 1'b0);
    step();
    check1("mrst_no_ack", wr_ack, 1'b0);
    reset_n = 1'b1;
    step();
    check1("mrst_no_ack_after", wr_ack, 1'b0);
    wr_req = 1'b1; wr_x = 10'd11; wr_y = 10'd12; wr_data = 32'hFEED_0001;
    step();
    check1("mrst_new_write", fb_write, 1'b1);
    checkw("mrst_new_data", 100'(fb_data_in), 100'hFEED0001);
    step(); step(); step();
    check1("mrst_new_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();
    check1("mrst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Sequences and shares the single Framebuffer access port between the UART-driven framebuffer writer and a pixel-chunk reader such as the convolution/VGA fetch path. Each requester uses a req/ack handshake. The arbiter latches the requester's operands, drives the Framebuffer `x_pos/y_pos/data_in/read/write` lines with correct write-hold and read-wait sequencing, and returns an acknowledge or error pulse. Writer has priority, with a starvation bound that guarantees reader progress.

## Interface
- `FB_W`, 640, valid x range is 0..FB_W-1
- `FB_H`, 480, valid y range is 0..FB_H-1
- `WRITE_CYCLES`, 3, cycles `fb_write` is held per write (≥1)
- `READ_TIMEOUT`, 64, max cycles waiting for `fb_data_ready` (≥2)
- `MAX_WR_BURST`, 4, consecutive write grants allowed while `rd_req` is pending (≥1)
- `clk` in 1: single clock, all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `wr_req` in 1: write request; held with operands stable until `wr_ack`/`range_err`
- `wr_x`, `wr_y` in 10 each: write pixel address
- `wr_data` in 32: write data word
- `wr_ack` out 1: one-cycle pulse, write completed
- `rd_req` in 1: read request; same holding rule as `wr_req`
- `rd_x`, `rd_y` in 10 each: read address
- `rd_ack` out 1: one-cycle pulse, `rd_data` valid
- `rd_data` out 100: last chunk read; holds until the next successful read
- `rd_timeout` out 1: one-cycle pulse, read abandoned
- `range_err` out 1: one-cycle pulse, request rejected for out-of-range address
- `fb_x_pos`, `fb_y_pos` out 10 each; `fb_data_in` out 32; `fb_read` out 1; `fb_write` out 1: Framebuffer drive
- `fb_data_chunk` in 100; `fb_data_ready` in 1: Framebuffer read return
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- States: IDLE, WRITE, READ, DONE.
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE and clears the counters and the starvation count.
- **IDLE arbitration**, at each edge:
  - Grant write if `wr_req` is high and (`rd_req` is low or `starve_cnt < MAX_WR_BURST`).
  - Otherwise grant read if `rd_req` is high.
  - On grant, latch x, y and data into internal registers. `fb_*` are driven only from the latched registers.
- **Range check at grant:** if x ≥ FB_W or y ≥ FB_H, go to DONE with `range_err` set. No `fb_read`/`fb_write` assertion occurs. The grant still counts for starvation accounting.
- **WRITE:**
  - `fb_write` = 1 for exactly WRITE_CYCLES cycles, with the latched address and data.
  - Then go to DONE with `wr_ack` set.
- **READ:**
  - `fb_read` = 1 with the latched address. `fb_data_ready` is sampled each cycle.
  - When `fb_data_ready` = 1: `rd_data` ← `fb_data_chunk`, set `rd_ack`, go to DONE.
  - If READ_TIMEOUT cycles pass without `fb_data_ready`: set `rd_timeout`, leave `rd_data` unchanged, go to DONE.
- **DONE:** lasts one cycle. Ack/err pulses are high here, and `fb_read`/`fb_write` are 0. The requester drops `req` in this cycle, then returns to IDLE.
  - A request that is still high in the cycle after DONE is treated as a new request.
- **Starvation counter (`starve_cnt`):**
  - Increments on each write grant while `rd_req` = 1, saturating at MAX_WR_BURST.
  - Clears on a read grant, or in any IDLE cycle where `rd_req` = 0.
- `fb_data_ready` outside READ is ignored.
- Simultaneous ready and timeout in the same cycle: ready wins and the read completes normally.
- Reset mid-operation: everything aborts, `fb_write`/`fb_read` drop asynchronously, and no ack is produced.

## Timing
- Write, cycle 0 = IDLE sees `wr_req`:
  - `fb_write` high in cycles 1..WRITE_CYCLES.
  - `wr_ack` in cycle WRITE_CYCLES+1.
  - Earliest next grant edge is the end of cycle WRITE_CYCLES+2.
- Read with Framebuffer latency L (`fb_data_ready` high in cycle L, L ≥ 1):
  - `fb_read` high in cycles 1..L.
  - `rd_ack` and new `rd_data` in cycle L+1.
- Timeout: `fb_read` high in cycles 1..READ_TIMEOUT, `rd_timeout` in cycle READ_TIMEOUT+1.
- Range error: `range_err` in cycle 1.
- Back-to-back writes, default parameters: one write per 5 cycles.

## Test plan
- **Single write:** `wr_req` with (8,8), data 0xDEADBEEF → `fb_write` high exactly 3 cycles with `fb_x_pos`=8, `fb_y_pos`=8, `fb_data_in`=0xDEADBEEF; `wr_ack` one pulse in cycle 4; `busy` low in cycle 5.
- **Read with latency 2:** `rd_req` (8,8), model returns chunk 100'h...A5 → `rd_ack` in cycle 3, `rd_data[7:0]`=0xA5, `fb_read` high cycles 1–2.
- **Starvation:** `wr_req` and `rd_req` both held continuously → exactly 4 write grants, then 1 read grant, then writes resume; the pattern repeats.
- **Timeout:** `rd_req` with `fb_data_ready` stuck low → `rd_timeout` pulse in cycle 65, `rd_data` unchanged, next write is serviced.
- **Range error:** `wr_req` x=640 → `range_err` in cycle 1; `fb_write` never asserted. `rd_req` y=480 behaves the same way.
- **Reset mid-write:** drop `reset_n` in cycle 2 of a write → `fb_write`=0 immediately, no `wr_ack`; after release, a new request completes normally.
